// File: rtl/sample_mixer.sv
// Voice mixer: polls each enabled voice over a shared req/ack bus, sums, attenuates
// and saturates to 16 bits, then strobes the result toward the codec conditioner.
module sample_mixer #(
  parameter int NUM_VOICES    = 4,
  parameter int VOICE_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  generate_next_sample,
  input  logic [NUM_VOICES-1:0] voice_enable,
  input  logic [1:0]            gain_shift,
  output logic [NUM_VOICES-1:0] voice_req,
  input  logic [NUM_VOICES-1:0] voice_ack,
  input  logic [15:0]           voice_sample,
  output logic [15:0]           new_sample_in,
  output logic                  latch_new_sample_in,
  output logic                  busy,
  output logic                  clip,
  output logic                  overrun,
  output logic                  timeout
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int AW = 16 + $clog2(NUM_VOICES) + 1;
  localparam int TW = $clog2(VOICE_TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] REQ  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_VOICES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(VOICE_TIMEOUT - 1);
  localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
  localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);

  logic [1:0]            state_reg;
  logic [NUM_VOICES-1:0] enable_reg;
  logic [1:0]            shift_reg;
  logic [IW-1:0]         idx_reg;
  logic [TW-1:0]         timer_reg;
  logic signed [AW-1:0]  acc_reg;

  logic [NUM_VOICES-1:0] idx_onehot;
  logic                  ack_sel;
  logic signed [AW-1:0]  sample_ext;
  logic signed [AW-1:0]  shifted;
  logic                  sat_hi;
  logic                  sat_lo;
  logic [15:0]           sat_val;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_sel
      assign idx_onehot[gi] = (idx_reg == IW'(gi));
    end
  endgenerate

  // Only the ack of the voice currently being requested is honoured.
  assign ack_sel    = |(voice_ack & idx_onehot & voice_req);
  assign sample_ext = {{(AW-16){voice_sample[15]}}, voice_sample};
  assign shifted    = acc_reg >>> shift_reg;
  assign sat_hi     = shifted > SAT_MAX;
  assign sat_lo     = shifted < SAT_MIN;
  assign sat_val    = sat_hi ? 16'h7fff : (sat_lo ? 16'h8000 : shifted[15:0]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg           <= IDLE;
      enable_reg          <= '0;
      shift_reg           <= '0;
      idx_reg             <= '0;
      timer_reg           <= '0;
      acc_reg             <= '0;
      voice_req           <= '0;
      new_sample_in       <= '0;
      latch_new_sample_in <= 1'b0;
      busy                <= 1'b0;
      clip                <= 1'b0;
      overrun             <= 1'b0;
      timeout             <= 1'b0;
    end else begin
      latch_new_sample_in <= 1'b0;
      clip                <= 1'b0;
      if (generate_next_sample && (state_reg != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (generate_next_sample) begin
            enable_reg <= voice_enable;
            shift_reg  <= gain_shift;
            acc_reg    <= '0;
            idx_reg    <= '0;
            timer_reg  <= '0;
            state_reg  <= SCAN;
            busy       <= 1'b1;
          end
        end
        SCAN: begin
          if (|(enable_reg & idx_onehot)) begin
            voice_req <= idx_onehot;
            timer_reg <= '0;
            state_reg <= REQ;
          end else if (idx_reg == LAST_IDX) begin
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + IW'(1);
          end
        end
        REQ: begin
          // An ack arriving on the expiry cycle still counts as a good sample.
          if (ack_sel || (timer_reg == TIMER_LAST)) begin
            if (ack_sel) begin
              acc_reg <= acc_reg + sample_ext;
            end else begin
              timeout <= 1'b1;
            end
            voice_req <= '0;
            timer_reg <= '0;
            if (idx_reg == LAST_IDX) begin
              state_reg <= DONE;
            end else begin
              idx_reg   <= idx_reg + IW'(1);
              state_reg <= SCAN;
            end
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        default: begin
          new_sample_in       <= sat_val;
          latch_new_sample_in <= 1'b1;
          clip                <= sat_hi | sat_lo;
          busy                <= 1'b0;
          state_reg           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_mixer.sv
// Directed bench for sample_mixer: behavioural voices answer requests, a monitor
// checks each latched sample against a queue of hand-computed expectations.
module tb_sample_mixer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        generate_next_sample = 1'b0;
  logic [3:0]  voice_enable = 4'b0;
  logic [1:0]  gain_shift = 2'b0;
  logic [3:0]  voice_req;
  logic [3:0]  voice_ack = 4'b0;
  logic [15:0] voice_sample = 16'h0;
  logic [15:0] new_sample_in;
  logic        latch_new_sample_in;
  logic        busy;
  logic        clip;
  logic        overrun;
  logic        timeout;

  sample_mixer #(.NUM_VOICES(4), .VOICE_TIMEOUT(255)) dut (
    .clk                 (clk),
    .reset               (reset),
    .generate_next_sample(generate_next_sample),
    .voice_enable        (voice_enable),
    .gain_shift          (gain_shift),
    .voice_req           (voice_req),
    .voice_ack           (voice_ack),
    .voice_sample        (voice_sample),
    .new_sample_in       (new_sample_in),
    .latch_new_sample_in (latch_new_sample_in),
    .busy                (busy),
    .clip                (clip),
    .overrun             (overrun),
    .timeout             (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] val;
    logic        clp;
    int          at;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   latch_cnt = 0;

  // Voice model configuration: delay N acks in the Nth REQ cycle, 0 never acks.
  logic [15:0] v_sample[4];
  int          v_delay[4];
  int          req_total[4];
  logic [3:0]  spur_ack = 4'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end else begin
      $display("[TB] ok   %s: %0h", name, got);
    end
  endtask

  initial begin
    int req_cnt[4];
    logic [3:0]  ack;
    logic [15:0] samp;
    for (int i = 0; i < 4; i++) begin
      req_cnt[i]   = 0;
      req_total[i] = 0;
    end
    forever begin
      @(negedge clk);
      ack  = spur_ack;
      samp = 16'h7777;
      for (int i = 0; i < 4; i++) begin
        if (voice_req[i] === 1'b1) begin
          req_cnt[i]++;
          req_total[i]++;
          if (v_delay[i] != 0 && req_cnt[i] == v_delay[i]) begin
            ack[i] = 1'b1;
            samp   = v_sample[i];
          end
        end else begin
          req_cnt[i] = 0;
        end
      end
      voice_ack    = ack;
      voice_sample = samp;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
      end else if (latch_new_sample_in) begin
        latch_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_latch: got strobe at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check({e.name, ".sample"}, 32'(new_sample_in), 32'(e.val));
          check({e.name, ".clip"}, 32'(clip), 32'(e.clp));
          check({e.name, ".latch_cycle"}, 32'(cyc), 32'(e.at));
          check({e.name, ".busy_at_latch"}, 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic set_voices(input logic [15:0] s0, input logic [15:0] s1,
                            input logic [15:0] s2, input logic [15:0] s3,
                            input int d0, input int d1, input int d2, input int d3);
    v_sample[0] = s0; v_sample[1] = s1; v_sample[2] = s2; v_sample[3] = s3;
    v_delay[0]  = d0; v_delay[1]  = d1; v_delay[2]  = d2; v_delay[3]  = d3;
  endtask

  task automatic pulse_gns(input logic [3:0] en, input logic [1:0] sh);
    @(negedge clk);
    voice_enable         = en;
    gain_shift           = sh;
    generate_next_sample = 1'b1;
  endtask

  task automatic push_exp(input logic [15:0] val, input logic clp, input int lat, input string name);
    exp_t e;
    e.val  = val;
    e.clp  = clp;
    e.at   = cyc + lat;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_latch(input int start, input int limit, input string name);
    int n;
    n = 0;
    while (latch_cnt == start && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (latch_cnt == start) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s.no_latch: got none after %0d cycles, expected a strobe", name, limit);
    end
    repeat (2) @(negedge clk);
  endtask

  // Enable/shift are scrambled right after the pulse; the captured copies must rule.
  task automatic run_mix(input logic [3:0] en, input logic [1:0] sh, input logic [15:0] val,
                         input logic clp, input int lat, input string name);
    int start;
    start = latch_cnt;
    pulse_gns(en, sh);
    push_exp(val, clp, lat, name);
    @(negedge clk);
    generate_next_sample = 1'b0;
    voice_enable         = ~en;
    gain_shift           = ~sh;
    wait_latch(start, lat + 50, name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_cleared(input string name);
    check({name, ".voice_req"}, 32'(voice_req), 32'd0);
    check({name, ".busy"}, 32'(busy), 32'd0);
    check({name, ".new_sample_in"}, 32'(new_sample_in), 32'd0);
    check({name, ".latch"}, 32'(latch_new_sample_in), 32'd0);
    check({name, ".clip"}, 32'(clip), 32'd0);
    check({name, ".overrun"}, 32'(overrun), 32'd0);
    check({name, ".timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    int snap;
    int start;
    set_voices(16'd100, 16'd200, -16'sd50, 16'd7, 1, 1, 1, 1);

    do_reset();
    check_cleared("reset");

    run_mix(4'b1111, 2'd0, 16'd257, 1'b0, 10, "mix_basic");

    snap = req_total[0] + req_total[1] + req_total[2] + req_total[3];
    run_mix(4'b0000, 2'd0, 16'd0, 1'b0, 6, "all_disabled");
    check("all_disabled.req_cycles", 32'(req_total[0] + req_total[1] + req_total[2] + req_total[3] - snap), 32'd0);

    set_voices(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 1, 1, 1, 1);
    run_mix(4'b1111, 2'd0, 16'h7fff, 1'b1, 10, "sat_pos");
    run_mix(4'b1111, 2'd2, 16'h7fff, 1'b0, 10, "shift2_fit");
    set_voices(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1, 1, 1, 1);
    run_mix(4'b1111, 2'd0, 16'h8000, 1'b1, 10, "sat_neg");
    set_voices(-16'sd3, 16'd0, 16'd0, 16'd0, 1, 1, 1, 1);
    run_mix(4'b1111, 2'd1, 16'hfffe, 1'b0, 10, "floor_shift");
    check("no_timeout_yet", 32'(timeout), 32'd0);

    // Ack on the final allowed REQ cycle is still taken.
    set_voices(16'd10, 16'd5, 16'd10, 16'd10, 1, 255, 1, 1);
    snap = req_total[1];
    run_mix(4'b1111, 2'd0, 16'd35, 1'b0, 264, "late_ack");
    check("late_ack.req_cycles", 32'(req_total[1] - snap), 32'd255);
    check("late_ack.timeout", 32'(timeout), 32'd0);

    set_voices(16'd10, 16'd5, 16'd10, 16'd10, 1, 0, 1, 1);
    snap = req_total[1];
    run_mix(4'b1111, 2'd0, 16'd30, 1'b0, 264, "no_ack");
    check("no_ack.req_cycles", 32'(req_total[1] - snap), 32'd255);
    check("no_ack.timeout", 32'(timeout), 32'd1);

    set_voices(16'd100, 16'd200, -16'sd50, 16'd7, 1, 1, 1, 1);
    run_mix(4'b1111, 2'd0, 16'd257, 1'b0, 10, "after_timeout");
    check("timeout_sticky", 32'(timeout), 32'd1);

    do_reset();
    check_cleared("reset2");

    // Second pulse three cycles into a mix must be ignored but flagged.
    set_voices(16'd1, 16'd2, 16'd3, 16'd4, 1, 1, 1, 1);
    start = latch_cnt;
    pulse_gns(4'b1111, 2'd0);
    push_exp(16'd10, 1'b0, 10, "overrun_mix");
    @(negedge clk);
    generate_next_sample = 1'b0;
    @(negedge clk);
    @(negedge clk);
    generate_next_sample = 1'b1;
    @(negedge clk);
    generate_next_sample = 1'b0;
    wait_latch(start, 60, "overrun_mix");
    repeat (20) @(negedge clk);
    check("overrun.latch_count", 32'(latch_cnt - start), 32'd1);
    check("overrun.flag", 32'(overrun), 32'd1);

    set_voices(16'd11, 16'd0, 16'd22, 16'd0, 3, 1, 1, 1);
    spur_ack = 4'b1010;
    run_mix(4'b0101, 2'd0, 16'd33, 1'b0, 10, "spurious_ack");
    spur_ack = 4'b0000;
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset while voice 1 sits in REQ waiting for an ack that never comes.
    set_voices(16'd100, 16'd200, -16'sd50, 16'd7, 1, 0, 1, 1);
    pulse_gns(4'b1111, 2'd0);
    push_exp(16'd0, 1'b0, 300, "aborted_mix");
    @(negedge clk);
    generate_next_sample = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_req.voice_req", 32'(voice_req), 32'b0010);
    reset = 1'b0;
    @(negedge clk);
    check_cleared("reset_mid_req");
    reset = 1'b1;

    set_voices(16'd100, 16'd200, -16'sd50, 16'd7, 1, 1, 1, 1);
    run_mix(4'b1111, 2'd0, 16'd257, 1'b0, 10, "after_abort");

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sample_mixer.md
Name: sample_mixer

Overview:
- Upstream producer for the codec conditioner.
- On each `generate_next_sample` pulse it fetches one 16-bit signed sample from each enabled voice generator over a shared req/ack bus.
- It sums the samples in a widened accumulator, applies an attenuation shift, saturates to 16 bits, then presents `new_sample_in` with a one-cycle `latch_new_sample_in` strobe.
- All work completes in tens of cycles, well inside the 48 kHz frame period.

Parameters:
- NUM_VOICES, 4, number of voice generators (1..8).
- VOICE_TIMEOUT, 255, maximum cycles spent waiting for one voice's ack before giving up on that voice.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- generate_next_sample  in  1  one-cycle pulse requesting the next mixed sample.
- voice_enable  in  NUM_VOICES  per-voice enable; captured when a mix starts.
- gain_shift  in  2  arithmetic right-shift applied to the sum (0..3); captured when a mix starts.
- voice_req  out  NUM_VOICES  one-hot request to voice idx.
- voice_ack  in  NUM_VOICES  voice idx indicates voice_sample is valid.
- voice_sample  in  16  signed sample from the acknowledging voice (shared bus).
- new_sample_in  out  16  mixed, saturated sample.
- latch_new_sample_in  out  1  one-cycle strobe; new_sample_in valid.
- busy  out  1  high whenever state is not IDLE.
- clip  out  1  one-cycle pulse, coincident with the latch strobe, when saturation occurred.
- overrun  out  1  sticky: generate_next_sample arrived while busy.
- timeout  out  1  sticky: some voice failed to ack within VOICE_TIMEOUT.

Behaviour:
- Reset (reset==0 at posedge, any state including mid-mix):
  - State goes to IDLE.
  - voice_req=0, new_sample_in=0, latch_new_sample_in=0, clip=0, overrun=0, timeout=0, accumulator=0, idx=0, timer=0.
- All outputs are registered.
- States: IDLE, SCAN, REQ, DONE.
- IDLE:
  - On generate_next_sample=1: capture voice_enable and gain_shift, acc=0, idx=0, go to SCAN.
  - Otherwise stay.
- SCAN (1 cycle per voice):
  - If the captured enable[idx]=1: go to REQ and assert voice_req[idx] from the next cycle.
  - Else if idx==NUM_VOICES-1: go to DONE.
  - Else idx++ and stay in SCAN.
- REQ:
  - voice_req[idx]=1 and timer counts cycles spent in REQ.
  - Only voice_ack[idx] is honoured; acks on other bits, and acks while voice_req is low, are ignored.
  - If voice_ack[idx]=1: acc += sign-extended voice_sample and voice_req drops on the next cycle.
  - Otherwise, when timer reaches VOICE_TIMEOUT: contribute 0, set timeout, drop voice_req.
  - An ack in the same cycle as timer expiry wins: the sample is added and timeout is not set.
  - Exit: idx==NUM_VOICES-1 goes to DONE; otherwise idx++, timer=0, go to SCAN.
- DONE (1 cycle):
  - s = acc >>> gain_shift (arithmetic, floor rounding: -3>>>1 = -2).
  - Saturate s to [-32768, 32767]; register the result into new_sample_in.
  - Next cycle: latch_new_sample_in=1 for exactly one cycle; clip=1 in that same cycle if saturation occurred.
  - Return to IDLE.
- Accumulator width is 16+ceil(log2(NUM_VOICES))+1 bits signed, so it never overflows.
- new_sample_in holds its value until the next DONE.
- Latency: latch asserted at cycle T0 + NUM_VOICES + (total REQ cycles) + 2, where T0 is the generate_next_sample cycle.
  - With all voices enabled and acking in their first REQ cycle, this is T0 + 2·NUM_VOICES + 2.
- generate_next_sample while busy:
  - The pulse is ignored (no restart); overrun is set.
  - It is sticky until reset; the current mix completes normally.
- A generate_next_sample in the same cycle as the latch strobe (state IDLE) starts a new mix normally.
- Changes to voice_enable or gain_shift during a mix have no effect until the next mix.

Test Plan:
- Reset, NUM_VOICES=4, all enabled, samples 100, 200, -50, 7, immediate ack, shift 0, gns at T0 -> latch at T0+10, new_sample_in=257, clip=0, busy low at T0+10.
- All disabled, gns at T0 -> no voice_req ever; latch at T0+6; new_sample_in=0.
- Four voices at 32767, shift 0 -> 32767 with clip=1. Same at shift 2 -> 32767 with clip=0. Four voices at -32768, shift 0 -> -32768 with clip=1. Voices -3,0,0,0 at shift 1 -> -2.
- Voice 1 never acks, VOICE_TIMEOUT=255, others 10 -> voice_req[1] high for 255 cycles; result 30; timeout=1 sticky. Repeat with ack on the 255th REQ cycle -> sample included, timeout stays 0.
- Second gns 3 cycles after the first -> overrun=1; exactly one latch strobe; result unaffected. Acks on a non-selected voice_ack bit -> ignored.
- Assert reset while in REQ -> next cycle voice_req=0, busy=0, new_sample_in=0, flags cleared. A subsequent gns mixes correctly.
